wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the pipeline and a multi-cycle unit (MDU) result FIFO.
// Optional macro WB_ARBITER_BYPASS_EN enables a zero-latency MDU write when the FIFO is idle.
module wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_reg_write,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_addr,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        reg_write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        stall_pipe,
    output logic [31:0] busy
);

    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]          fifoAddr_q [FIFO_DEPTH];
    logic [31:0]         fifoData_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
    logic                stall_q, stall_d;
    logic [31:0]         busy_q, busy_d;

    logic        pipePending;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        selPipe;
    logic        selFifo;
    logic        selBypass;
    logic        pushEn;
    logic        popEn;
    logic        starveCond;
    logic [4:0]  headAddr;
    logic [31:0] headData;
    logic [4:0]  selAddr;
    logic [31:0] selData;

    assign headAddr = fifoAddr_q[rdPtr_q];
    assign headData = fifoData_q[rdPtr_q];

    // Source selection: the pipeline wins unless starvation has forced a FIFO drain.
    always_comb begin
        pipePending = pipe_valid && pipe_reg_write && (pipe_addr != 5'd0);
        fifoEmpty   = (count_q == '0);
        fifoFull    = (count_q == CNT_W'(FIFO_DEPTH));
        selPipe     = !stall_q && pipePending;
        selFifo     = !fifoEmpty && (stall_q || !pipePending);
`ifdef WB_ARBITER_BYPASS_EN
        selBypass   = fifoEmpty && !pipePending && !stall_q && mdu_valid;
`else
        selBypass   = 1'b0;
`endif
        popEn       = selFifo;
        mdu_ready   = !fifoFull || popEn;
        pushEn      = mdu_valid && mdu_ready && (mdu_addr != 5'd0) && !selBypass;
        starveCond  = fifoFull && !popEn;
    end

    always_comb begin
        selAddr = 5'd0;
        selData = 32'd0;
        if (selPipe) begin
            selAddr = pipe_addr;
            selData = pipe_data;
        end else if (selFifo) begin
            selAddr = headAddr;
            selData = headData;
        end else if (selBypass) begin
            selAddr = mdu_addr;
            selData = mdu_data;
        end
        reg_write  = !rst && (selPipe || selFifo || selBypass) && (selAddr != 5'd0);
        write_addr = selAddr;
        write_data = selData;
    end

    always_comb begin
        wrPtr_d = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = popEn  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        starveCnt_d = '0;
        if (starveCond) begin
            starveCnt_d = (starveCnt_q == STARVE_W'(STARVE_LIMIT)) ? starveCnt_q
                                                                   : starveCnt_q + STARVE_W'(1);
        end

        // Stall holds until the FIFO has fully drained, not merely until it is no longer full.
        stall_d = stall_q;
        if (count_d == '0) begin
            stall_d = 1'b0;
        end else if (starveCond && (starveCnt_d == STARVE_W'(STARVE_LIMIT))) begin
            stall_d = 1'b1;
        end
    end

    // Clear on an MDU write first so that a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (selFifo) begin
            busy_d[headAddr] = 1'b0;
        end else if (selBypass) begin
            busy_d[mdu_addr] = 1'b0;
        end
        if (mdu_issue && (mdu_issue_addr != 5'd0)) begin
            busy_d[mdu_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            starveCnt_q <= '0;
            stall_q     <= 1'b0;
            busy_q      <= 32'd0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            starveCnt_q <= starveCnt_d;
            stall_q     <= stall_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn && !rst) begin
            fifoAddr_q[wrPtr_q] <= mdu_addr;
            fifoData_q[wrPtr_q] <= mdu_data;
        end
    end

    assign stall_pipe = stall_q;
    assign busy       = busy_q;

endmodule
